// File: rtl/dot_product_pkg.sv
// Shared helpers for the streaming dot-product engine: log2, saturation
// limits, saturating add and parameter legality checks.
package dot_product_pkg;

  localparam int WIDE = 64;

  typedef logic signed [WIDE-1:0] wide_t;

  typedef struct packed {
    logic  ovf;
    wide_t value;
  } sat_res_t;

  function automatic int log2_ceil(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic wide_t sat_max(input int s);
    return (wide_t'(1) <<< (s - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t sat_min(input int s);
    return -(wide_t'(1) <<< (s - 1));
  endfunction

  // Operands are S-bit values sign-extended to WIDE, so the raw sum cannot wrap.
  function automatic sat_res_t sat_add(input wide_t a, input wide_t b, input int s);
    sat_res_t r;
    wide_t    sum;
    sum     = a + b;
    r.ovf   = 1'b0;
    r.value = sum;
    if (sum > sat_max(s)) begin
      r.value = sat_max(s);
      r.ovf   = 1'b1;
    end else if (sum < sat_min(s)) begin
      r.value = sat_min(s);
      r.ovf   = 1'b1;
    end
    return r;
  endfunction

  function automatic bit params_legal(input int n, input int m, input int s, input int depth);
    bit ok;
    ok = 1'b1;
    if (n < 2 || n > 18) ok = 1'b0;
    if (m < 1 || m > 16 || (m & (m - 1)) != 0) ok = 1'b0;
    if (s < 2 * n + log2_ceil(m) || s > WIDE - 2) ok = 1'b0;
    if (depth < 2) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/dot_product_result_fifo.sv
// First-word-fall-through result FIFO; exposes its occupancy so the
// producer can run credit-based flow control against it.
module dot_product_result_fifo #(
  parameter int W     = 49,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           srst,
  input  logic                           push,
  input  logic [W-1:0]                   din,
  input  logic                           pop,
  output logic [W-1:0]                   dout,
  output logic                           valid,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          pop_ok;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid  = (count_reg != '0);
  assign pop_ok = pop & valid;
  assign count  = count_reg;
  // Gate the head word so an empty FIFO presents zero rather than stale data.
  assign dout   = valid ? mem[rd_ptr_reg] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)   wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop_ok) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  push_not_full: assert property (@(posedge clk) disable iff (srst)
    !(push && count_reg == CW'(DEPTH)));

endmodule

// File: rtl/dot_product_stream.sv
// Streaming signed dot-product: multiply, adder tree, accumulator, result FIFO.
// Define DOT_PRODUCT_SATURATE_EN for a saturating accumulator with o_overflow.
module dot_product_stream
  import dot_product_pkg::*;
#(
  parameter int N         = 8,
  parameter int M         = 4,
  parameter int S         = 48,
  parameter int RES_DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [M*N-1:0]     i_a,
  input  logic [M*N-1:0]     i_b,
  input  logic               i_valid,
  input  logic               i_first,
  input  logic               i_last,
  output logic               o_ready,
  output logic [S-1:0]       o_sum,
  output logic               o_overflow,
  output logic               o_valid,
  input  logic               i_ready
);

`ifdef DOT_PRODUCT_SATURATE_EN
  localparam int FW = S + 1;
`else
  localparam int FW = S;
`endif
  localparam int CW = $clog2(RES_DEPTH + 1);

  if (!params_legal(N, M, S, RES_DEPTH)) begin : g_illegal
    $error("dot_product_stream: illegal parameter set");
  end

  logic                    accept;
  logic                    s1_valid, s1_first, s1_last;
  logic signed [2*N-1:0]   s1_prod [M];
  logic signed [S-1:0]     prod_ext [M];
  logic signed [S-1:0]     tree_sum;
  logic                    s2_valid, s2_first, s2_last;
  logic signed [S-1:0]     s2_sum;
  logic signed [S-1:0]     acc_reg, acc_next;
  logic                    in_vector_reg;
  logic                    eff_first;
  logic                    s3_push_reg;
  logic [1:0]              lasts;
  logic [CW-1:0]           fifo_count;
  logic [FW-1:0]           fifo_din, fifo_dout;
  logic                    pop;

  // Credits: every last already in flight has a FIFO slot reserved for it.
  assign lasts   = 2'(s1_valid & s1_last) + 2'(s2_valid & s2_last) + 2'(s3_push_reg);
  assign o_ready = (int'(fifo_count) + int'(lasts)) < RES_DEPTH;
  assign accept  = i_valid & o_ready;
  assign pop     = o_valid & i_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= accept;
      s1_first <= accept & i_first;
      s1_last  <= accept & i_last;
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      for (int j = 0; j < M; j++)
        s1_prod[j] <= $signed(i_a[j*N +: N]) * $signed(i_b[j*N +: N]);
    end
  end

  for (genvar gi = 0; gi < M; gi++) begin : g_ext
    assign prod_ext[gi] = S'(s1_prod[gi]);
  end

  always_comb begin
    tree_sum = '0;
    for (int j = 0; j < M; j++) tree_sum = tree_sum + prod_ext[j];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s2_last  <= s1_last;
    end
    if (s1_valid) s2_sum <= tree_sum;
  end

  // A beat arriving outside a vector starts a fresh one even without i_first.
  assign eff_first = s2_first | ~in_vector_reg;

`ifdef DOT_PRODUCT_SATURATE_EN
  logic     ovf_reg, ovf_next;
  sat_res_t sat_res;

  always_comb begin
    sat_res  = sat_add(wide_t'(acc_reg), wide_t'(s2_sum), S);
    acc_next = eff_first ? s2_sum : S'(sat_res.value);
    ovf_next = eff_first ? 1'b0 : (ovf_reg | sat_res.ovf);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)       ovf_reg <= 1'b0;
    else if (s2_valid) ovf_reg <= ovf_next;
  end

  assign fifo_din   = {ovf_reg, acc_reg};
  assign o_sum      = fifo_dout[S-1:0];
  assign o_overflow = fifo_dout[S];
`else
  always_comb begin
    acc_next = eff_first ? s2_sum : acc_reg + s2_sum;
  end

  assign fifo_din   = acc_reg;
  assign o_sum      = fifo_dout;
  assign o_overflow = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      acc_reg       <= '0;
      in_vector_reg <= 1'b0;
      s3_push_reg   <= 1'b0;
    end else begin
      s3_push_reg <= s2_valid & s2_last;
      if (s2_valid) begin
        acc_reg       <= acc_next;
        in_vector_reg <= ~s2_last;
      end
    end
  end

  dot_product_result_fifo #(
    .W     (FW),
    .DEPTH (RES_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .srst  (i_reset),
    .push  (s3_push_reg),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .valid (o_valid),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_dot_product_stream.sv
// Randomised and directed bench for dot_product_stream against a vector-level
// arithmetic model; honours DOT_PRODUCT_SATURATE_EN for the expected values.
module tb_dot_product_stream;

  localparam int N         = 8;
  localparam int M         = 4;
  localparam int S         = 20;
  localparam int RES_DEPTH = 2;
  localparam longint SMAX  = (longint'(1) <<< (S - 1)) - 1;
  localparam longint SMIN  = -(longint'(1) <<< (S - 1));

  logic           i_clk = 1'b0;
  logic           i_reset;
  logic [M*N-1:0] i_a, i_b;
  logic           i_valid, i_first, i_last, i_ready;
  logic           o_ready, o_overflow, o_valid;
  logic [S-1:0]   o_sum;

  always #5 i_clk = ~i_clk;

  dot_product_stream #(.N(N), .M(M), .S(S), .RES_DEPTH(RES_DEPTH)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_a        (i_a),
    .i_b        (i_b),
    .i_valid    (i_valid),
    .i_first    (i_first),
    .i_last     (i_last),
    .o_ready    (o_ready),
    .o_sum      (o_sum),
    .o_overflow (o_overflow),
    .o_valid    (o_valid),
    .i_ready    (i_ready)
  );

  typedef struct {
    longint sum;
    bit     ovf;
  } exp_t;

  exp_t   exp_q[$];
  int     checks = 0;
  int     errors = 0;
  int     accepted = 0;
  int     pops = 0;
  longint last_sum = 0;
  bit     last_ovf = 0;
  longint m_acc = 0;
  bit     m_ovf = 0;
  bit     m_in_vec = 0;
  bit     rand_ready = 0;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] splat(input int v);
    logic [7:0] e;
    e = v[7:0];
    return {4{e}};
  endfunction

  // Vector-level reference: dot product per beat, then accumulate per vector.
  task automatic model_accept(input logic [31:0] a, input logic [31:0] b,
                              input bit first, input bit last);
    longint s;
    exp_t   e;
    s = 0;
    for (int j = 0; j < M; j++)
      s += longint'($signed(a[j*8 +: 8])) * longint'($signed(b[j*8 +: 8]));
    if (first || !m_in_vec) begin
      m_acc = s;
      m_ovf = 0;
    end else begin
      m_acc = m_acc + s;
`ifdef DOT_PRODUCT_SATURATE_EN
      if (m_acc > SMAX) begin
        m_acc = SMAX;
        m_ovf = 1;
      end else if (m_acc < SMIN) begin
        m_acc = SMIN;
        m_ovf = 1;
      end
`else
      m_acc = (m_acc <<< (64 - S)) >>> (64 - S);
`endif
    end
    m_in_vec = !last;
    accepted++;
    if (last) begin
      e.sum = m_acc;
      e.ovf = m_ovf;
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input bit first, input bit last);
    int wait_cnt;
    @(negedge i_clk);
    i_a = a; i_b = b; i_first = first; i_last = last; i_valid = 1'b1;
    wait_cnt = 0;
    while (!o_ready && wait_cnt < 200) begin
      @(negedge i_clk);
      wait_cnt++;
    end
    if (!o_ready) check("ready_timeout", 0, 1);
    else model_accept(a, b, first, last);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0; i_first = 1'b0; i_last = 1'b0;
  endtask

  task automatic drain();
    int cnt;
    cnt = 0;
    while ((exp_q.size() != 0 || o_valid) && cnt < 300) begin
      @(negedge i_clk);
      cnt++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  // Monitor: every pop is compared in order with the model's queue.
  logic         prev_stall = 0;
  logic [S-1:0] prev_sum = '0;
  always @(negedge i_clk) begin
    if (i_reset) begin
      prev_stall = 0;
    end else begin
      if (o_valid && prev_stall) check("hold_sum", $signed(o_sum), $signed(prev_sum));
      prev_stall = o_valid && !i_ready;
      prev_sum   = o_sum;
      if (o_valid && i_ready) begin
        exp_t e;
        pops++;
        last_sum = longint'($signed(o_sum));
        last_ovf = o_overflow;
        if (exp_q.size() == 0) begin
          check("spurious_pop", 1, 0);
        end else begin
          e = exp_q.pop_front();
          $display("pop %0d: sum %0d ovf %0d (model %0d %0d)", pops, $signed(o_sum),
                   o_overflow, e.sum, e.ovf);
          check("sum", $signed(o_sum), e.sum);
          check("ovf", o_overflow, e.ovf);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge i_clk);
      #2;
      if (rand_ready) i_ready = ($urandom % 4) != 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_acc, base_pops, len;
    bit f0, f;
    logic [31:0] ra, rb;

    i_reset = 1'b1; i_a = '0; i_b = '0; i_valid = 0; i_first = 0; i_last = 0; i_ready = 1;
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);
    check("rst_ready", o_ready, 1);
    check("rst_valid", o_valid, 0);
    check("rst_sum", $signed(o_sum), 0);
    check("rst_ovf", o_overflow, 0);

    // Basic 70 and pipeline latency
    send({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 1, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      check("latency_valid", o_valid, (k == 3) ? 1 : 0);
    end
    drain();
    check("t1_sum", last_sum, 70);

    // Two beats of -128*-128, then a beat without first restarts from zero
    send(splat(-128), splat(-128), 1, 0);
    send(splat(-128), splat(-128), 0, 1);
    drain();
    check("t2_sum", last_sum, 131072);
    send(splat(1), splat(1), 0, 1);
    drain();
    check("t2_restart", last_sum, 4);

    // Backpressure: credits stop acceptance after RES_DEPTH results
    @(posedge i_clk); #2; i_ready = 1'b0;
    base_acc = accepted;
    base_pops = pops;
    fork
      begin
        for (int i = 0; i < 5; i++) send(splat(i + 1), splat(1), 1, 1);
      end
      begin
        repeat (10) @(negedge i_clk);
        check("bp_accepted", accepted - base_acc, 2);
        check("bp_ready", o_ready, 0);
        @(posedge i_clk); #2; i_ready = 1'b1;
      end
    join
    drain();
    check("bp_pops", pops - base_pops, 5);

    // Long vector: saturates or wraps depending on the build
    for (int i = 0; i < 8; i++) send(splat(-128), splat(-128), i == 0, i == 7);
    drain();
`ifdef DOT_PRODUCT_SATURATE_EN
    check("sat_sum", last_sum, 524287);
    check("sat_ovf", last_ovf, 1);
`else
    check("wrap_sum", last_sum, -524288);
    check("wrap_ovf", last_ovf, 0);
`endif

    // First mid-vector abandons the partial sum
    base_pops = pops;
    for (int i = 0; i < 3; i++) send(splat(1), splat(1), i == 0, 0);
    send(splat(2), splat(3), 1, 0);
    send(splat(1), splat(1), 0, 1);
    drain();
    check("restart_sum", last_sum, 28);
    check("restart_pops", pops - base_pops, 1);

    // Reset right after a last beat drops the result
    base_pops = pops;
    send(splat(5), splat(5), 1, 1);
    @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    exp_q.delete();
    m_in_vec = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge i_clk);
      check("post_reset_valid", o_valid, 0);
    end
    check("post_reset_pops", pops - base_pops, 0);
    send(splat(1), splat(2), 1, 1);
    drain();
    check("post_reset_sum", last_sum, 8);

    // Randomised vectors with random downstream stalls
    rand_ready = 1;
    for (int v = 0; v < 30; v++) begin
      len = $urandom_range(1, 5);
      f0 = ($urandom % 5) != 0;
      for (int k = 0; k < len; k++) begin
        ra = $urandom;
        rb = $urandom;
        f = (k == 0) ? f0 : (($urandom % 8) == 0);
        send(ra, rb, f, k == len - 1);
      end
    end
    rand_ready = 0;
    @(posedge i_clk); #2; i_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dot_product_stream.md
# dot_product_stream

Streaming signed integer dot-product engine, the parametrised successor to the fixed 4-lane 8×8 MLP dot-product block. Each accepted beat carries M lane pairs of N-bit two's-complement operands. The block runs a registered multiply stage, a registered adder-tree stage and an accumulator across a first/last-delimited vector. Finished sums go into a small result FIFO that supports downstream backpressure, with credit-based input flow control so no result is ever dropped.

## Interface
- N, 8, element width in bits (signed), 2..18
- M, 4, lanes per beat, power of two, 1..16
- S, 48, result/accumulator width; must satisfy S ≥ 2N+log2(M)
- RES_DEPTH, 4, result FIFO depth, ≥ 2
- i_clk  in  1  clock; single clock domain
- i_reset  in  1  synchronous, active-high reset
- i_a  in  M*N  lane operands A, lane j at [j*N +: N]
- i_b  in  M*N  lane operands B, same packing
- i_valid  in  1  beat valid
- i_first  in  1  beat is first of a vector (qualified by i_valid)
- i_last  in  1  beat is last of a vector (qualified by i_valid)
- o_ready  out  1  block can accept a beat
- o_sum  out  S  finished dot product (signed)
- o_overflow  out  1  sum saturated (macro builds only)
- o_valid  out  1  o_sum valid
- i_ready  in  1  downstream accepts o_sum

## Operation
- Beat accepted when i_valid & o_ready.
- Stage 1 registers M products, each 2N bits, sign-extended.
- Stage 2 registers the adder-tree sum, sign-extended to S bits.
- Stage 3 holds the accumulator: acc = first ? sum : acc + sum.
  - On a last beat, the stage-3 result plus its overflow flag are written to the FIFO.
- i_first & i_last on the same beat produce a one-beat vector.
- A beat following a last without i_first is treated as first, i.e. the accumulator restarts from zero.
- i_first mid-vector discards the partial sum. No result is emitted for the abandoned vector.
- Credit rule: o_ready = (fifo_count + lasts_in_pipeline) < RES_DEPTH, where lasts_in_pipeline counts last-flags in stages 1–3.
  - A credit is released on a FIFO pop (o_valid & i_ready).
- FIFO is first-word-fall-through. Simultaneous push and pop keeps the count unchanged. Push to a full FIFO is impossible by construction; assert this in simulation.

## Timing
- Reset values: o_ready=1 the cycle after reset deasserts, o_valid=0, o_sum=0, o_overflow=0. Accumulator, pipeline valids and FIFO are cleared.
- Latency: last beat accepted at edge t → o_valid high after edge t+3, provided the FIFO was empty.
- o_sum and o_overflow are held stable while o_valid & !i_ready.
- Throughput is one beat per cycle while credits are available.
- o_ready is combinational from registered state only; it never depends on i_valid.
- i_reset mid-vector or mid-drain drops all in-flight data and queued results. No partial result is emitted afterwards.

## Configuration
- DOT_PRODUCT_SATURATE_EN defined:
  - The accumulator add saturates to the S-bit signed max/min.
  - o_overflow reports a saturation anywhere in that vector (sticky per vector, cleared on first).
- DOT_PRODUCT_SATURATE_EN undefined:
  - The accumulator wraps modulo 2^S.
  - o_overflow is tied to 0 and no FIFO storage is spent on it.

## Structure
- Package dot_product_pkg holds:
  - the log2 helper;
  - S-width saturation constants (SAT_MAX, SAT_MIN);
  - the sat_add function;
  - the parameter legality checks used by elaboration-time assertions.
- Sub-module dot_product_result_fifo: parametrised FWFT FIFO (width S+1, depth RES_DEPTH) exposing its count for the credit logic.
- Top level contains the multiply, adder-tree and accumulator stages plus the credit counter.

## Test plan
- N=8, M=4: a={1,2,3,4}, b={5,6,7,8}, first&last at edge t, i_ready=1 → o_sum=70, o_valid high after edge t+3 for one cycle.
- Two beats of all lanes a=-128, b=-128 (first, then last) → o_sum=131072; a following beat with no i_first starts a new vector from 0.
- i_ready=0, RES_DEPTH=2, five one-beat vectors offered back-to-back → o_ready drops after 2 accepted; release i_ready → results pop in order, no loss or duplication.
- S=20, macro defined: 8 beats of all -128×-128 lanes (total 524288) → o_sum=524287, o_overflow=1. Macro undefined → o_sum=-524288 (wrapped), o_overflow=0.
- i_first asserted mid-vector after 3 beats → only the restarted vector's sum is emitted.
- i_reset pulsed one cycle after a last beat → no o_valid follows; next vector {1,1,1,1}·{2,2,2,2} → 8.
